seg_display_sched: RTL and testbench

Scheduler that shares the 4-digit seven-segment display between three requesters and drives the display driver's `in0..in3`, `game` and `clk1` inputs. Requester 0 is the always-present background (for example the score). Requesters 1 and 2 are timed overlay messages with fixed priority, 2 over 1. The block holds each granted message for a fixed time, returns a completion pulse, and generates the blink phase used by the driver to blank the anodes.

---
 rtl/seg_sched_pkg.sv | 11 +
 rtl/seg_tick_gen.sv | 27 ++
 rtl/seg_display_sched.sv | 122 ++++++++++++
 tb/tb_seg_display_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_sched_pkg;

  typedef enum logic {BG, SHOW} state_t;

  localparam int unsigned REQ_BG    = 0;
  localparam int unsigned REQ_MSG   = 1;
  localparam int unsigned REQ_ALERT = 2;
  localparam int unsigned NREQ      = 3;

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running tick divider: tick is high while the count sits at TICK_DIV-1.
module seg_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_sched.sv
// Shares the 4-digit display between the background and two timed overlays.
// Optional: define SEG_SCHED_PREEMPT_EN to let requester 2 preempt requester 1.
module seg_display_sched
  import seg_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned HOLD_TICKS  = 2000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [15:0]     data0,
  input  logic [15:0]     data1,
  input  logic [15:0]     data2,
  input  logic [NREQ-1:0] blink_i,
  output logic [3:0]      in0,
  output logic [3:0]      in1,
  output logic [3:0]      in2,
  output logic [3:0]      in3,
  output logic            game,
  output logic            clk1,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy
);

  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  state_t          state;
  logic [HW-1:0]   hold;
  logic [BW-1:0]   blink_cnt;
  logic            phase;
  logic            phase_next;
  logic            blink_lat;
  logic            tick;
  logic            clear;
  logic            grant;
  logic            preempt;
  logic [NREQ-1:0] next_gnt;
  logic [15:0]     next_data;
  logic            next_blink;

  seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    next_gnt   = req[REQ_ALERT] ? NREQ'(3'b100) : NREQ'(3'b010);
    next_data  = req[REQ_ALERT] ? data2 : data1;
    next_blink = req[REQ_ALERT] ? blink_i[REQ_ALERT] : blink_i[REQ_MSG];
    grant      = (state == BG) && (req[REQ_ALERT] || req[REQ_MSG]);
`ifdef SEG_SCHED_PREEMPT_EN
    preempt    = (state == SHOW) && gnt[REQ_MSG] && req[REQ_MSG] && req[REQ_ALERT];
`else
    preempt    = 1'b0;
`endif
    clear      = grant || preempt;
    phase_next = (tick && (blink_cnt == BW'(BLINK_TICKS - 1))) ? ~phase : phase;
  end

  // Blink counter and phase run every cycle; a grant overrides them below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BG;
      hold      <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      blink_lat <= 1'b0;
      {in3, in2, in1, in0} <= '0;
      game      <= 1'b0;
      clk1      <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      done  <= '0;
      phase <= phase_next;
      if (tick) begin
        blink_cnt <= (blink_cnt == BW'(BLINK_TICKS - 1)) ? '0 : blink_cnt + 1'b1;
      end
      if (grant || preempt) begin
        state     <= SHOW;
        gnt       <= next_gnt;
        busy      <= 1'b1;
        {in3, in2, in1, in0} <= next_data;
        blink_lat <= next_blink;
        game      <= next_blink;
        clk1      <= 1'b0;
        hold      <= HW'(HOLD_TICKS);
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (state == BG) begin
        {in3, in2, in1, in0} <= data0;
        game <= blink_i[REQ_BG];
        clk1 <= blink_i[REQ_BG] & phase_next;
      end else if ((req & gnt) == '0) begin
        // Granted requester withdrew: abort without a completion pulse.
        state <= BG;
        gnt   <= '0;
        busy  <= 1'b0;
      end else begin
        clk1 <= blink_lat & phase_next;
        if (tick) begin
          if (hold == HW'(1)) begin
            done  <= gnt;
            state <= BG;
            gnt   <= '0;
            busy  <= 1'b0;
          end else begin
            hold <= hold - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched with TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2.
module tb_seg_display_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  blink_i = '0;
  logic [15:0] data0 = 16'h1234;
  logic [15:0] data1 = 16'hABCD;
  logic [15:0] data2 = 16'h5678;
  logic [3:0]  in0, in1, in2, in3;
  logic        game, clk1, busy;
  logic [2:0]  gnt, done;
  logic [24:0] st;
  logic [24:0] exp_st;
  int          errors = 0;
  int          checks = 0;

  // {gnt, busy, done, game, clk1, in3, in2, in1, in0}
  assign st = {gnt, busy, done, game, clk1, in3, in2, in1, in0};

  always #5 clk = ~clk;

  seg_display_sched #(.TICK_DIV(4), .HOLD_TICKS(3), .BLINK_TICKS(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .blink_i(blink_i),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .game(game), .clk1(clk1), .gnt(gnt), .done(done), .busy(busy)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(2);
    exp_st = '0;
    checks++;
    if (st !== exp_st) begin $display("FAIL reset_hold got=%h exp=%h", st, exp_st); errors++; end
    rst = 1'b0;
    step(1);
    exp_st = {3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h1234};
    checks++;
    if (st !== exp_st) begin $display("FAIL reset_release got=%h exp=%h", st, exp_st); errors++; end
  endtask

  task automatic test_single;
    req = 3'b010;
    step(1);
    exp_st = {3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL single_grant got=%h exp=%h", st, exp_st); errors++; end
    step(11);
    checks++;
    if (st !== exp_st) begin $display("FAIL single_hold got=%h exp=%h", st, exp_st); errors++; end
    step(1);
    exp_st = {3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL single_done got=%h exp=%h", st, exp_st); errors++; end
    req = 3'b000;
    step(1);
    exp_st = {3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h1234};
    checks++;
    if (st !== exp_st) begin $display("FAIL single_bg got=%h exp=%h", st, exp_st); errors++; end
  endtask

  task automatic test_both;
    req = 3'b110;
    step(1);
    exp_st = {3'b100, 1'b1, 3'b000, 1'b0, 1'b0, 16'h5678};
    checks++;
    if (st !== exp_st) begin $display("FAIL both_grant2 got=%h exp=%h", st, exp_st); errors++; end
    step(11);
    checks++;
    if (st !== exp_st) begin $display("FAIL both_hold2 got=%h exp=%h", st, exp_st); errors++; end
    step(1);
    exp_st = {3'b000, 1'b0, 3'b100, 1'b0, 1'b0, 16'h5678};
    checks++;
    if (st !== exp_st) begin $display("FAIL both_done2 got=%h exp=%h", st, exp_st); errors++; end
    req = 3'b010;
    step(1);
    exp_st = {3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL both_grant1 got=%h exp=%h", st, exp_st); errors++; end
    step(12);
    exp_st = {3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL both_done1 got=%h exp=%h", st, exp_st); errors++; end
    req = 3'b000;
    step(1);
  endtask

  task automatic test_midhold;
    req = 3'b010;
    step(5);
    req = 3'b110;
    step(1);
`ifdef SEG_SCHED_PREEMPT_EN
    exp_st = {3'b100, 1'b1, 3'b000, 1'b0, 1'b0, 16'h5678};
    checks++;
    if (st !== exp_st) begin $display("FAIL preempt_grant got=%h exp=%h", st, exp_st); errors++; end
    step(11);
    checks++;
    if (st !== exp_st) begin $display("FAIL preempt_hold got=%h exp=%h", st, exp_st); errors++; end
    step(1);
    exp_st = {3'b000, 1'b0, 3'b100, 1'b0, 1'b0, 16'h5678};
    checks++;
    if (st !== exp_st) begin $display("FAIL preempt_done2 got=%h exp=%h", st, exp_st); errors++; end
    req = 3'b010;
    step(1);
    exp_st = {3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL preempt_restart1 got=%h exp=%h", st, exp_st); errors++; end
    step(11);
    checks++;
    if (st !== exp_st) begin $display("FAIL preempt_fullhold1 got=%h exp=%h", st, exp_st); errors++; end
    step(1);
    exp_st = {3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL preempt_done1 got=%h exp=%h", st, exp_st); errors++; end
    req = 3'b000;
    step(1);
`else
    exp_st = {3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL nopreempt_keep got=%h exp=%h", st, exp_st); errors++; end
    step(6);
    checks++;
    if (st !== exp_st) begin $display("FAIL nopreempt_hold got=%h exp=%h", st, exp_st); errors++; end
    step(1);
    exp_st = {3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL nopreempt_done1 got=%h exp=%h", st, exp_st); errors++; end
    req = 3'b100;
    step(1);
    exp_st = {3'b100, 1'b1, 3'b000, 1'b0, 1'b0, 16'h5678};
    checks++;
    if (st !== exp_st) begin $display("FAIL nopreempt_grant2 got=%h exp=%h", st, exp_st); errors++; end
    step(12);
    exp_st = {3'b000, 1'b0, 3'b100, 1'b0, 1'b0, 16'h5678};
    checks++;
    if (st !== exp_st) begin $display("FAIL nopreempt_done2 got=%h exp=%h", st, exp_st); errors++; end
    req = 3'b000;
    step(1);
`endif
  endtask

  task automatic test_blink;
    blink_i = 3'b010;
    req = 3'b010;
    step(1);
    exp_st = {3'b010, 1'b1, 3'b000, 1'b1, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL blink_grant got=%h exp=%h", st, exp_st); errors++; end
    for (int k = 1; k <= 11; k++) begin
      step(1);
      checks++;
      if ({game, clk1} !== {1'b1, (k >= 8)}) begin
        $display("FAIL blink_phase k=%0d got=%b%b exp=1%b", k, game, clk1, (k >= 8));
        errors++;
      end
    end
    step(1);
    checks++;
    if (done !== 3'b010) begin $display("FAIL blink_done got=%b exp=010", done); errors++; end
    req = 3'b000;
    blink_i = 3'b000;
    step(1);
    exp_st = {3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h1234};
    checks++;
    if (st !== exp_st) begin $display("FAIL blink_bg got=%h exp=%h", st, exp_st); errors++; end
  endtask

  task automatic test_abort;
    req = 3'b010;
    step(3);
    req = 3'b000;
    step(1);
    exp_st = {3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 16'hABCD};
    checks++;
    if (st !== exp_st) begin $display("FAIL abort_edge got=%h exp=%h", st, exp_st); errors++; end
    step(1);
    exp_st = {3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h1234};
    checks++;
    if (st !== exp_st) begin $display("FAIL abort_bg got=%h exp=%h", st, exp_st); errors++; end
  endtask

  task automatic test_reset_show;
    req = 3'b010;
    step(1);
    step(5);
    #2 rst = 1'b1;
    #1;
    exp_st = '0;
    checks++;
    if (st !== exp_st) begin $display("FAIL rst_async got=%h exp=%h", st, exp_st); errors++; end
    step(2);
    checks++;
    if (st !== exp_st) begin $display("FAIL rst_held got=%h exp=%h", st, exp_st); errors++; end
    rst = 1'b0;
    req = 3'b000;
    step(1);
    exp_st = {3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h1234};
    checks++;
    if (st !== exp_st) begin $display("FAIL rst_bg got=%h exp=%h", st, exp_st); errors++; end
  endtask

  initial begin
    test_reset;
    test_single;
    test_both;
    test_midhold;
    test_blink;
    test_abort;
    test_reset_show;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
